// File: rtl/branch_recovery_ctrl_pkg.sv
// Shared types and constants for the branch-recovery controller.
// This file holds the prediction-status struct, the recovery states and the PC mux constant.
package branch_recovery_ctrl_pkg;

    typedef struct packed {
        logic [2:0] pc_sel;
        logic       failed_prediction;
    } BRANCH_PREDICTION_STATUS_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } RECOVERY_STATE_t;

    localparam logic [2:0] PC_SEL_NEXT = 3'd0;

endpackage

// File: rtl/branch_recovery_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
// Once the count reaches all-ones, it holds that value and does not wrap to zero.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Branch-recovery controller for predict-not-taken: redirects the PC on a misprediction,
// squashes the wrong-path fetch for FLUSH_CYCLES cycles, stalls on load-use, counts outcomes.
module branch_recovery_ctrl
    import branch_recovery_ctrl_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  BRANCH_PREDICTION_STATUS_t pred_info,
    input  logic                      de_valid,
    input  logic                      load_use_stall,
    input  logic                      ctr_clear,
    output logic [2:0]                pc_sel_out,
    output logic                      pc_write,
    output logic                      if_de_write,
    output logic                      if_de_flush,
    output logic                      de_ex_flush,
    output logic                      busy,
    output logic [WIDTH-1:0]          resolved_count,
    output logic [WIDTH-1:0]          mispredict_count
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    RECOVERY_STATE_t r_state;
    RECOVERY_STATE_t w_next_state;
    logic [1:0]      r_flush_left;
    logic [1:0]      w_next_flush_left;
    logic            w_accept;
    logic            w_mispredict;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_flush_left <= 2'd0;
        end else begin
            r_state      <= w_next_state;
            r_flush_left <= w_next_flush_left;
        end
    end

    // Outputs are combinational so the redirect lands on the same edge the branch leaves DE.
    always_comb begin
        w_next_state      = r_state;
        w_next_flush_left = r_flush_left;
        w_accept          = 1'b0;
        w_mispredict      = 1'b0;
        pc_sel_out        = PC_SEL_NEXT;
        pc_write          = 1'b1;
        if_de_write       = 1'b1;
        if_de_flush       = 1'b0;
        de_ex_flush       = 1'b0;

        if (RST) begin
            pc_write    = 1'b0;
            if_de_write = 1'b0;
            if_de_flush = 1'b1;
            de_ex_flush = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_use_stall) begin
                        pc_write    = 1'b0;
                        if_de_write = 1'b0;
                        de_ex_flush = 1'b1;
                    end else begin
                        w_accept     = de_valid;
                        w_mispredict = de_valid && pred_info.failed_prediction;
                        if (w_mispredict) begin
                            pc_sel_out  = pred_info.pc_sel;
                            if_de_flush = 1'b1;
                            if (FLUSH_CYCLES > 1) begin
                                w_next_state      = FLUSH;
                                w_next_flush_left = FLUSH_INIT;
                            end
                        end
                    end
                end
                FLUSH: begin
                    // DE content is wrong-path here, so its status inputs are not consulted.
                    if_de_flush       = 1'b1;
                    w_next_flush_left = r_flush_left - 2'd1;
                    if (r_flush_left <= 2'd1) begin
                        w_next_state = IDLE;
                    end
                end
                default: begin
                    w_next_state      = IDLE;
                    w_next_flush_left = 2'd0;
                end
            endcase
        end
    end

    assign busy = (r_state == FLUSH);

    sat_counter #(.WIDTH(WIDTH)) u_resolved_ctr (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_accept),
        .clr   (ctr_clear),
        .count (resolved_count)
    );

    sat_counter #(.WIDTH(WIDTH)) u_mispredict_ctr (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_mispredict),
        .clr   (ctr_clear),
        .count (mispredict_count)
    );

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Scoreboard bench for branch_recovery_ctrl: a 2-cycle-flush and a 3-cycle-flush instance,
// both 4-bit counters, driven by directed vectors whose expected outputs are queued per cycle.
module tb_branch_recovery_ctrl;
    import branch_recovery_ctrl_pkg::*;

    logic                      CLK = 1'b0;
    logic                      RST = 1'b1;
    BRANCH_PREDICTION_STATUS_t pred_info = '0;
    logic                      de_valid = 1'b0;
    logic                      load_use_stall = 1'b0;
    logic                      ctr_clear = 1'b0;

    logic [2:0] a_sel, b_sel;
    logic       a_pcw, a_ifw, a_iff, a_def, a_busy;
    logic       b_pcw, b_ifw, b_iff, b_def, b_busy;
    logic [3:0] a_res, a_mis, b_res, b_mis;

    always #5 CLK = ~CLK;

    branch_recovery_ctrl #(.WIDTH(4), .FLUSH_CYCLES(2)) dut2 (
        .CLK(CLK), .RST(RST), .pred_info(pred_info), .de_valid(de_valid),
        .load_use_stall(load_use_stall), .ctr_clear(ctr_clear),
        .pc_sel_out(a_sel), .pc_write(a_pcw), .if_de_write(a_ifw),
        .if_de_flush(a_iff), .de_ex_flush(a_def), .busy(a_busy),
        .resolved_count(a_res), .mispredict_count(a_mis)
    );

    branch_recovery_ctrl #(.WIDTH(4), .FLUSH_CYCLES(3)) dut3 (
        .CLK(CLK), .RST(RST), .pred_info(pred_info), .de_valid(de_valid),
        .load_use_stall(load_use_stall), .ctr_clear(ctr_clear),
        .pc_sel_out(b_sel), .pc_write(b_pcw), .if_de_write(b_ifw),
        .if_de_flush(b_iff), .de_ex_flush(b_def), .busy(b_busy),
        .resolved_count(b_res), .mispredict_count(b_mis)
    );

    // Control vector order: {pc_write, if_de_write, if_de_flush, de_ex_flush, busy}
    localparam logic [4:0] NRM = 5'b11000;
    localparam logic [4:0] RDR = 5'b11100;
    localparam logic [4:0] FLS = 5'b11101;
    localparam logic [4:0] STL = 5'b00010;
    localparam logic [4:0] RSV = 5'b00110;

    typedef struct {
        string      tag;
        int         d;
        logic [2:0] sel;
        logic [4:0] ctrl;
        logic [3:0] res;
        logic [3:0] mis;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [3:0] sat(input int v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    task automatic step(input string tag, input int d, input logic [2:0] psel, input logic fp,
                        input logic dv, input logic lus, input logic clr, input logic rp,
                        input logic [2:0] esel, input logic [4:0] ectrl,
                        input logic [3:0] eres, input logic [3:0] emis);
        exp_t e;
        @(posedge CLK);
        #1;
        pred_info.pc_sel            = psel;
        pred_info.failed_prediction = fp;
        de_valid                    = dv;
        load_use_stall              = lus;
        ctr_clear                   = clr;
        if (rp) RST = 1'b1;
        e.tag  = tag;
        e.d    = d;
        e.sel  = esel;
        e.ctrl = ectrl;
        e.res  = eres;
        e.mis  = emis;
        q.push_back(e);
        if (rp) begin
            @(negedge CLK);
            #1;
            RST = 1'b0;
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t       e;
        logic [2:0] s;
        logic [4:0] c;
        logic [3:0] r, m;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.d == 2) begin
                s = a_sel; c = {a_pcw, a_ifw, a_iff, a_def, a_busy}; r = a_res; m = a_mis;
            end else begin
                s = b_sel; c = {b_pcw, b_ifw, b_iff, b_def, b_busy}; r = b_res; m = b_mis;
            end
            vectors++;
            if (s !== e.sel || c !== e.ctrl || r !== e.res || m !== e.mis) begin
                miscompares++;
                $display("FAIL %s dut%0d: got sel=%0d ctrl=%b res=%0d mis=%0d, expected sel=%0d ctrl=%b res=%0d mis=%0d",
                         e.tag, e.d, s, c, r, m, e.sel, e.ctrl, e.res, e.mis);
            end
        end
    end

    initial begin
        repeat (2) @(posedge CLK);
        step("reset", 2, 3'd0, 0, 0, 0, 0, 1, 3'd0, RSV, 4'd0, 4'd0);

        for (int k = 0; k < 5; k++)
            step("correct", 2, 3'd0, 0, 1, 0, 0, 0, 3'd0, NRM, 4'(k), 4'd0);
        step("correct_cnt", 2, 3'd0, 0, 0, 0, 0, 0, 3'd0, NRM, 4'd5, 4'd0);

        step("mp_redirect", 2, 3'd3, 1, 1, 0, 0, 0, 3'd3, RDR, 4'd5, 4'd0);
        step("mp_flush",    2, 3'd0, 0, 0, 0, 0, 0, 3'd0, FLS, 4'd6, 4'd1);
        step("mp_idle",     2, 3'd0, 0, 0, 0, 0, 0, 3'd0, NRM, 4'd6, 4'd1);

        step("stall",        2, 3'd5, 1, 1, 1, 0, 0, 3'd0, STL, 4'd6, 4'd1);
        step("stall_redir",  2, 3'd5, 1, 1, 0, 0, 0, 3'd5, RDR, 4'd6, 4'd1);
        step("stall_flush",  2, 3'd0, 0, 0, 0, 0, 0, 3'd0, FLS, 4'd7, 4'd2);
        step("stall_idle",   2, 3'd0, 0, 0, 0, 0, 0, 3'd0, NRM, 4'd7, 4'd2);

        for (int k = 0; k < 20; k++) begin
            step("sat_redir", 2, 3'd7, 1, 1, 0, 0, 0, 3'd7, RDR, sat(7 + k), sat(2 + k));
            step("sat_flush", 2, 3'd0, 0, 0, 0, 0, 0, 3'd0, FLS, sat(8 + k), sat(3 + k));
        end
        step("sat_hold",    2, 3'd0, 0, 0, 0, 0, 0, 3'd0, NRM, 4'd15, 4'd15);
        step("clr_redir",   2, 3'd2, 1, 1, 0, 1, 0, 3'd2, RDR, 4'd15, 4'd15);
        step("clr_flush",   2, 3'd0, 0, 0, 0, 0, 0, 3'd0, FLS, 4'd0, 4'd0);
        step("clr_idle",    2, 3'd0, 0, 0, 0, 0, 0, 3'd0, NRM, 4'd0, 4'd0);

        step("reset3",      3, 3'd0, 0, 0, 0, 0, 1, 3'd0, RSV, 4'd0, 4'd0);
        step("f3_accept",   3, 3'd0, 0, 1, 0, 0, 0, 3'd0, NRM, 4'd0, 4'd0);
        step("f3_redirect", 3, 3'd4, 1, 1, 0, 0, 0, 3'd4, RDR, 4'd1, 4'd0);
        step("f3_ignore1",  3, 3'd6, 1, 1, 1, 0, 0, 3'd0, FLS, 4'd2, 4'd1);
        step("f3_ignore2",  3, 3'd6, 1, 1, 1, 0, 0, 3'd0, FLS, 4'd2, 4'd1);
        step("f3_idle",     3, 3'd0, 0, 0, 0, 0, 0, 3'd0, NRM, 4'd2, 4'd1);

        step("rmf_redirect", 3, 3'd1, 1, 1, 0, 0, 0, 3'd1, RDR, 4'd2, 4'd1);
        step("rmf_pulse",    3, 3'd0, 0, 0, 0, 0, 1, 3'd0, RSV, 4'd0, 4'd0);
        step("rmf_idle",     3, 3'd0, 0, 0, 0, 0, 0, 3'd0, NRM, 4'd0, 4'd0);
        step("rmf_accept",   3, 3'd0, 0, 1, 0, 0, 0, 3'd0, NRM, 4'd0, 4'd0);
        step("rmf_count",    3, 3'd0, 0, 0, 0, 0, 0, 3'd0, NRM, 4'd1, 4'd0);

        repeat (3) @(posedge CLK);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked vectors, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_recovery_ctrl.md
# branch_recovery_ctrl

Pipeline branch-recovery controller on the consumer side of the predict-not-taken scheme. It takes the per-cycle `BRANCH_PREDICTION_STATUS_t` from the DE stage and decides whether to redirect the PC. On a misprediction it squashes the wrong-path instructions for a fixed number of cycles, and it holds the front end on load-use stalls. It also keeps saturating branch-resolution and misprediction counters for performance measurement. It sits between the DE-stage predictor, the PC mux, and the IF/DE and DE/EX pipeline registers.

## Interface
Parameters:
- `WIDTH`, 32, width of the performance counters.
- `FLUSH_CYCLES`, 2, number of cycles `if_de_flush` is asserted per misprediction. Legal range is 1..3.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous and active-high.
- `pred_info`  in  `BRANCH_PREDICTION_STATUS_t`  fields `pc_sel[2:0]` and `failed_prediction` from the DE stage.
- `de_valid`  in  1  DE holds a real instruction, not a bubble.
- `load_use_stall`  in  1  load-use hazard request from hazard detection.
- `ctr_clear`  in  1  synchronous clear of both counters.
- `pc_sel_out`  out  3  PC mux select; 0 selects PC+4.
- `pc_write`  out  1  PC register enable.
- `if_de_write`  out  1  IF/DE register enable.
- `if_de_flush`  out  1  load a bubble into IF/DE.
- `de_ex_flush`  out  1  load a bubble into DE/EX.
- `busy`  out  1  high while in FLUSH.
- `resolved_count`  out  `WIDTH`  accepted DE instructions.
- `mispredict_count`  out  `WIDTH`  accepted mispredictions.

## Operation
The controller has two states, IDLE and FLUSH, plus a 2-bit down-counter `flush_left`.

Definitions:
- **accept** = IDLE & `de_valid` & !`load_use_stall`.
- **mispredict** = accept & `pred_info.failed_prediction`.

IDLE, in priority order:
- **`load_use_stall`:**
  - `pc_write`=0, `if_de_write`=0, `de_ex_flush`=1, `pc_sel_out`=0.
  - The DE instruction is held and re-evaluated next cycle; it is not counted.
- **mispredict:**
  - `pc_sel_out`=`pred_info.pc_sel`, `pc_write`=1, `if_de_write`=1, `if_de_flush`=1, `de_ex_flush`=0.
  - If `FLUSH_CYCLES`>1: go to FLUSH with `flush_left`=`FLUSH_CYCLES`-1. Otherwise stay in IDLE.
- **otherwise:**
  - `pc_sel_out`=0, `pc_write`=1, `if_de_write`=1, both flushes 0.

FLUSH:
- `if_de_flush`=1, `pc_write`=1, `if_de_write`=1, `pc_sel_out`=0, `de_ex_flush`=0.
- `pred_info`, `de_valid` and `load_use_stall` are ignored (wrong-path or bubble content).
- `flush_left` decrements each cycle. When it is 1, the next state is IDLE.

Counters:
- `resolved_count` increments on accept; `mispredict_count` increments on mispredict.
- Both saturate at all-ones and never wrap.
- `ctr_clear` has priority over increment; the cleared value is 0 at the next edge.

Reset:
- While `RST` is high: state=IDLE, `flush_left`=0, counters=0.
- Outputs while `RST` is high: `pc_write`=0, `if_de_write`=0, `if_de_flush`=1, `de_ex_flush`=1, `pc_sel_out`=0, `busy`=0.
- Reset asserted mid-FLUSH aborts the flush immediately (asynchronous).

## Timing
- All control outputs are combinational from state and inputs. The redirect takes effect at the same edge where the branch leaves DE, so redirect latency is 0 cycles.
- `if_de_flush` is high for exactly `FLUSH_CYCLES` consecutive cycles per misprediction, counting the redirect cycle.
- `busy` is registered-state based: high for `FLUSH_CYCLES`-1 cycles.
- Back-to-back mispredictions: a mispredict is impossible during FLUSH, so the next one is accepted no earlier than the first IDLE cycle.
- A counter update is visible the cycle after the accept edge.

## Structure
- Add to `pipeline_structs_defs.svh`:
  - `RECOVERY_STATE_t` enum {IDLE, FLUSH}.
  - `PC_SEL_NEXT` = 3'd0.
- Reuse the existing `BRANCH_PREDICTION_STATUS_t`.
- One sub-module, `sat_counter` (parameter `WIDTH`; inputs `inc`, `clr`), instantiated twice.

## Test plan
- **Correct prediction:** reset, then `de_valid`=1, `pc_sel`=0 for 5 cycles → `pc_sel_out`=0, no flushes, `resolved_count`=5, `mispredict_count`=0.
- **Mispredict, default flush:** `FLUSH_CYCLES`=2, `de_valid`=1, `pc_sel`=3, `failed_prediction`=1 → that cycle `pc_sel_out`=3 and `if_de_flush`=1; next cycle `busy`=1, `if_de_flush`=1, `pc_sel_out`=0; then IDLE; `mispredict_count`=1.
- **Stall then mispredict:** `load_use_stall`=1 with a failed prediction for 1 cycle → `pc_write`=0, `de_ex_flush`=1, counters unchanged. Next cycle, stall low → redirect occurs and both counters increment by 1.
- **Ignored inputs in FLUSH:** `FLUSH_CYCLES`=3, mispredict, then failed_prediction=1 and stall=1 driven during FLUSH → ignored; `if_de_flush` is high for exactly 3 cycles; `mispredict_count`=1.
- **Saturation and clear:** `WIDTH`=4, 20 mispredicts → `mispredict_count`=15. Then `ctr_clear`=1 together with a mispredict → count=0.
- **Reset mid-flush:** `RST` pulsed during FLUSH → outputs take their reset values immediately, state=IDLE, counters=0, `busy`=0.
